// File: rtl/mmm_pkg.sv
// mmm_pkg: FSM encoding, iteration-count helper and digit-width legality limits
// shared by the Montgomery multiplier and its processing element.
package mmm_pkg;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINISH, S_DONE} mmm_state_t;

    localparam int W_BITS_MIN = 1;
    localparam int W_BITS_MAX = 16;

    function automatic int mmm_iter(input int k_bits, input int w_bits);
        return k_bits / w_bits;
    endfunction

    function automatic bit mmm_cfg_ok(input int k_bits, input int w_bits);
        return w_bits >= W_BITS_MIN && w_bits <= W_BITS_MAX && (k_bits % w_bits) == 0;
    endfunction

endpackage

// File: rtl/mmm_digit_step.sv
// mmm_digit_step: one combinational radix-2^W Montgomery iteration,
// P' = (P + a*B + q*m) / 2^W with q chosen so the low W bits cancel.
module mmm_digit_step
    import mmm_pkg::*;
#(
    parameter int K_BITS = 256,
    parameter int W_BITS = 4
) (
    input  logic [K_BITS:0]   p,
    input  logic [W_BITS-1:0] a,
    input  logic [K_BITS-1:0] b,
    input  logic [K_BITS-1:0] m,
    input  logic [W_BITS-1:0] m_inv,
    output logic [K_BITS:0]   p_next,
    output logic [W_BITS-1:0] q
);
    localparam int S_BITS = K_BITS + W_BITS + 2;

    logic [W_BITS-1:0] t;
    logic [S_BITS-1:0] sum;
    logic              unused_bits;

    // With P < 2m the shifted sum stays below 2m, so its top bit and low digit are always zero.
    always_comb begin
        t           = p[W_BITS-1:0] + a * b[W_BITS-1:0];
        q           = t * m_inv;
        sum         = S_BITS'(p) + S_BITS'(a) * S_BITS'(b) + S_BITS'(q) * S_BITS'(m);
        p_next      = sum[K_BITS+W_BITS:W_BITS];
        unused_bits = ^{sum[S_BITS-1], sum[W_BITS-1:0]};
    end

endmodule

// File: rtl/montgomery_mmm_radix.sv
// montgomery_mmm_radix: digit-serial Montgomery multiplier, o_P = A*B*2^-K mod m.
// Define MMM_FINAL_SUB_EN for the registered final subtraction (o_P < m); otherwise o_P < 2m.
module montgomery_mmm_radix
    import mmm_pkg::*;
#(
    parameter int K_BITS = 256,
    parameter int W_BITS = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [K_BITS-1:0] i_A,
    input  logic [K_BITS-1:0] i_B,
    input  logic [K_BITS-1:0] i_m,
    input  logic [W_BITS-1:0] i_mInv,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [K_BITS-1:0] o_P,
    output logic              o_Busy
);
    localparam int ITER   = mmm_iter(K_BITS, W_BITS);
    localparam int C_BITS = $clog2(ITER + 1);

    generate
        if (!mmm_cfg_ok(K_BITS, W_BITS)) begin : g_bad_cfg
            $error("montgomery_mmm_radix: W_BITS must be 1..16 and divide K_BITS");
        end
    endgenerate

    mmm_state_t        state;
    logic [K_BITS-1:0] a_r, b_r, m_r;
    logic [W_BITS-1:0] minv_r;
    logic [K_BITS:0]   p_r, p_next;
    logic [W_BITS-1:0] unused_q;
    logic [C_BITS-1:0] cnt;
    logic              last;

    assign last = cnt == C_BITS'(ITER - 1);

    // a_r shifts right each iteration so the current digit is always its low W bits.
    mmm_digit_step #(.K_BITS(K_BITS), .W_BITS(W_BITS)) u_step (
        .p      (p_r),
        .a      (a_r[W_BITS-1:0]),
        .b      (b_r),
        .m      (m_r),
        .m_inv  (minv_r),
        .p_next (p_next),
        .q      (unused_q)
    );

`ifdef MMM_FINAL_SUB_EN
    logic [K_BITS+1:0] diff;
    assign diff = {1'b0, p_r} - {2'b0, m_r};
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            o_Ready <= 1'b1;
            o_Valid <= 1'b0;
            o_Busy  <= 1'b0;
            o_P     <= '0;
            p_r     <= '0;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            m_r     <= '0;
            minv_r  <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_Valid && o_Ready) begin
                    a_r     <= i_A;
                    b_r     <= i_B;
                    m_r     <= i_m;
                    minv_r  <= i_mInv;
                    p_r     <= '0;
                    cnt     <= '0;
                    state   <= S_COMPUTE;
                    o_Ready <= 1'b0;
                    o_Busy  <= 1'b1;
                end
                S_COMPUTE: begin
                    p_r <= p_next;
                    a_r <= a_r >> W_BITS;
                    cnt <= cnt + C_BITS'(1);
                    if (last) begin
`ifdef MMM_FINAL_SUB_EN
                        state   <= S_FINISH;
`else
                        state   <= S_DONE;
                        o_P     <= p_next[K_BITS-1:0];
                        o_Valid <= 1'b1;
                        o_Busy  <= 1'b0;
`endif
                    end
                end
`ifdef MMM_FINAL_SUB_EN
                S_FINISH: begin
                    o_P     <= diff[K_BITS+1] ? p_r[K_BITS-1:0] : diff[K_BITS-1:0];
                    state   <= S_DONE;
                    o_Valid <= 1'b1;
                    o_Busy  <= 1'b0;
                end
`endif
                S_DONE: if (i_Ready) begin
                    state   <= S_IDLE;
                    o_Valid <= 1'b0;
                    o_Ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mmm_radix.sv
// tb_montgomery_mmm_radix: directed checks of the Montgomery multiplier at K=8/W=2,
// K=8/W=1 against a radix-2 model, and K=256/W=16 against modular identities.
module tb_montgomery_mmm_radix;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

`ifdef MMM_FINAL_SUB_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       v2, rdy2, ov2, or2, busy2;
    logic [7:0] a2, b2, m2, p2;
    logic [1:0] mi2;
    montgomery_mmm_radix #(.K_BITS(8), .W_BITS(2)) u_w2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v2), .o_Ready(or2), .i_A(a2), .i_B(b2),
        .i_m(m2), .i_mInv(mi2), .o_Valid(ov2), .i_Ready(rdy2), .o_P(p2), .o_Busy(busy2));

    logic       v1, rdy1, ov1, or1, busy1;
    logic [7:0] a1, b1, m1, p1;
    logic [0:0] mi1;
    montgomery_mmm_radix #(.K_BITS(8), .W_BITS(1)) u_w1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v1), .o_Ready(or1), .i_A(a1), .i_B(b1),
        .i_m(m1), .i_mInv(mi1), .o_Valid(ov1), .i_Ready(rdy1), .o_P(p1), .o_Busy(busy1));

    logic         v16, rdy16, ov16, or16, busy16;
    logic [255:0] a16, b16, m16, p16;
    logic [15:0]  mi16;
    montgomery_mmm_radix #(.K_BITS(256), .W_BITS(16)) u_w16 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v16), .o_Ready(or16), .i_A(a16), .i_B(b16),
        .i_m(m16), .i_mInv(mi16), .o_Valid(ov16), .i_Ready(rdy16), .o_P(p16), .o_Busy(busy16));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_w2(input logic [7:0] a, b, m, input logic [1:0] mi,
                         output logic [7:0] p, output int lat);
        a2 = a; b2 = b; m2 = m; mi2 = mi; v2 = 1'b1;
        tick();
        v2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
        lat = 0;
        while (!ov2 && lat < 50) begin
            tick();
            lat++;
        end
        p = p2;
    endtask

    task automatic op_w1(input logic [7:0] a, b, m, output logic [7:0] p, output int lat);
        a1 = a; b1 = b; m1 = m; mi1 = 1'b1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 50) begin
            tick();
            lat++;
        end
        p = p1;
    endtask

    task automatic op_w16(input logic [255:0] a, b, m, input logic [15:0] mi,
                          output logic [255:0] p, output int lat);
        a16 = a; b16 = b; m16 = m; mi16 = mi; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin
            tick();
            lat++;
        end
        p = p16;
    endtask

    task automatic rel_w2();
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
    endtask

    task automatic rel_w1();
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
    endtask

    task automatic rel_w16();
        rdy16 = 1'b1;
        tick();
        rdy16 = 1'b0;
    endtask

    // Classic bit-serial Montgomery: add a_i*B, add m when odd, halve.
    function automatic logic [7:0] r2_ref(input logic [7:0] a, b, m);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) p = p + {2'b0, b};
            if (p[0]) p = p + {2'b0, m};
            p = p >> 1;
        end
`ifdef MMM_FINAL_SUB_EN
        if (p >= {2'b0, m}) p = p - {2'b0, m};
`endif
        return p[7:0];
    endfunction

    // Newton iteration for m^-1 mod 2^16, then negate.
    function automatic logic [15:0] minv16(input logic [15:0] m);
        logic [15:0] y;
        y = m;
        for (int i = 0; i < 4; i++) y = y * (16'd2 - m * y);
        return -y;
    endfunction

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]   p8, m8, x8, y8;
        logic [255:0] p256, m256, x256, y256;
        logic [511:0] lhs, rhs;
        int           lat;
        v2 = 0; rdy2 = 0; a2 = 0; b2 = 0; m2 = 0; mi2 = 0;
        v1 = 0; rdy1 = 0; a1 = 0; b1 = 0; m1 = 0; mi1 = 0;
        v16 = 0; rdy16 = 0; a16 = 0; b16 = 0; m16 = 0; mi16 = 0;
        #12;
        check("rst_ready", or2, 1);
        check("rst_valid", ov2, 0);
        check("rst_p", p2, 0);
        check("rst_busy", busy2, 0);
        #10 rst_n = 1'b1;
        tick();
        op_w2(8'd5, 8'd7, 8'd13, 2'd3, p8, lat);
        check("w2_5x7", p8, 1);
        check("w2_latency", lat, 4 + EXTRA);
        check("w2_busy_done", busy2, 0);
        rel_w2();
        check("w2_rel_valid", ov2, 0);
        check("w2_rel_ready", or2, 1);
        op_w2(8'd12, 8'd12, 8'd13, 2'd3, p8, lat);
        check("w2_12x12", p8, 3);
        repeat (10) tick();
        check("w2_hold_valid", ov2, 1);
        check("w2_hold_p", p2, 3);
        rel_w2();
        check("w2_hold_rel_valid", ov2, 0);
        check("w2_hold_rel_ready", or2, 1);
        op_w2(8'd0, 8'd11, 8'd13, 2'd3, p8, lat);
        check("w2_a0", p8, 0);
        rel_w2();
        op_w2(8'd9, 8'd0, 8'd13, 2'd3, p8, lat);
        check("w2_b0", p8, 0);
        rel_w2();
        a2 = 8'd5; b2 = 8'd7; m2 = 8'd13; mi2 = 2'd3; v2 = 1'b1;
        tick();
        a2 = 8'd12; b2 = 8'd12; rdy2 = 1'b1;
        check("w2_ready_busy", or2, 0);
        check("w2_busy", busy2, 1);
        tick();
        tick();
        v2 = 1'b0; rdy2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 50) begin
            tick();
            lat++;
        end
        check("w2_ignore_valid", ov2, 1);
        check("w2_ignore_p", p2, 1);
        rel_w2();
        a2 = 8'd12; b2 = 8'd12; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", ov2, 0);
        check("arst_p", p2, 0);
        check("arst_ready", or2, 1);
        check("arst_busy", busy2, 0);
        #2 rst_n = 1'b1;
        tick();
        check("arst_no_partial", ov2, 0);
        op_w2(8'd5, 8'd7, 8'd13, 2'd3, p8, lat);
        check("w2_after_rst", p8, 1);
        rel_w2();
        op_w1(8'd0, 8'd9, 8'd13, p8, lat);
        check("w1_a0", p8, 0);
        check("w1_latency", lat, 8 + EXTRA);
        rel_w1();
        check("w1_rel_ready", or1, 1);
        for (int i = 0; i < 200; i++) begin
            m8 = 8'($urandom_range(1, 63) * 2 + 1);
            x8 = 8'($urandom_range(0, int'(m8) - 1));
            y8 = 8'($urandom_range(0, int'(m8) - 1));
            op_w1(x8, y8, m8, p8, lat);
            check("w1_radix2", p8, r2_ref(x8, y8, m8));
            rel_w1();
        end
        m256 = '0;
        m256[255:240] = 16'h7fff;
        m256[0] = 1'b1;
        op_w16('0, 256'd12345, m256, minv16(m256[15:0]), p256, lat);
        check("w16_a0", p256, 0);
        check("w16_latency", lat, 16 + EXTRA);
        check("w16_busy_done", busy16, 0);
        rel_w16();
        check("w16_rel_ready", or16, 1);
        for (int i = 0; i < 25; i++) begin
            for (int j = 0; j < 8; j++) begin
                m256[j*32 +: 32] = $urandom;
                x256[j*32 +: 32] = $urandom;
                y256[j*32 +: 32] = $urandom;
            end
            m256[255] = 1'b0;
            m256[0] = 1'b1;
            x256 = x256 % m256;
            y256 = y256 % m256;
            op_w16(x256, y256, m256, minv16(m256[15:0]), p256, lat);
            lhs = {p256, 256'b0} % {256'b0, m256};
            rhs = ({256'b0, x256} * {256'b0, y256}) % {256'b0, m256};
            check("w16_congruence", lhs[255:0], rhs[255:0]);
`ifdef MMM_FINAL_SUB_EN
            check("w16_below_m", {255'b0, p256 < m256}, 1);
`else
            check("w16_below_2m", {255'b0, {1'b0, p256} < {m256, 1'b0}}, 1);
`endif
            rel_w16();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
